// File: rtl/jk_pkg.sv
// jk_pkg: shared types and helpers for the JK-cell based modulo counter.
//   jk_pair_t    - {j, k} excitation pair for one JK bit cell
//   jk_excite    - minimal-toggle excitation for one bit that must move from q to n
//   jk_max_count - terminal count (MODULUS-1) used to clamp loads and detect wraps
package jk_pkg;

    typedef struct packed {
        logic j;
        logic k;
    } jk_pair_t;

    localparam int unsigned DEFAULT_MODULUS = 10;

    // J only where the bit rises and K only where it falls, so nothing toggles
    // unnecessarily.
    function automatic jk_pair_t jk_excite(input logic n, input logic q);
        jk_pair_t p;
        p.j = n & ~q;
        p.k = ~n & q;
        return p;
    endfunction

    function automatic int unsigned jk_max_count(input int unsigned modulus);
        return modulus - 1;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// jk_cell: one JK storage bit with synchronous active-high clear.
// Ports:
//   clk - clock, state changes on posedge
//   clr - synchronous clear, forces q to 0
//   j   - set request
//   k   - reset request
//   q   - registered bit value
module jk_cell (
    input  logic clk,
    input  logic clr,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            q_q <= 1'b0;
        end else begin
            q_q <= (j & ~q_q) | (~k & q_q);
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// jk_mod_counter: loadable, cascadable modulo-MODULUS up/down counter built from
// WIDTH JK bit cells driven by a combinational excitation stage.
// Build option: define JK_MOD_COUNTER_SAT_EN to saturate at the range ends
// instead of wrapping.
// Ports:
//   clk     - clock
//   clr     - synchronous active-high reset (highest priority)
//   en      - count enable
//   up      - direction, 1 = increment, 0 = decrement
//   ld      - synchronous parallel load (beats en)
//   d       - load value, clamped to MODULUS-1
//   q       - current count, registered
//   tc      - terminal count, combinational; drives en of the next stage
//   wrapped - sticky flag, set on a wrap or saturation hit, cleared by clr/ld
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = DEFAULT_MODULUS
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(jk_max_count(MODULUS));
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    // One extra bit so MODULUS == 2**WIDTH still compares correctly.
    localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] n;
    jk_pair_t [WIDTH-1:0] ex;
    logic wrapped_q;

    assign tc = en & (up ? (q == MAX_COUNT) : (q == '0));

    always_comb begin
        n = q;
        if (clr) begin
            n = '0;
        end else if (ld) begin
            n = ({1'b0, d} >= MOD_EXT) ? MAX_COUNT : d;
        end else if (en) begin
`ifdef JK_MOD_COUNTER_SAT_EN
            if (up) begin
                n = (q == MAX_COUNT) ? MAX_COUNT : q + ONE;
            end else begin
                n = (q == '0) ? '0 : q - ONE;
            end
`else
            if (up) begin
                n = (q == MAX_COUNT) ? '0 : q + ONE;
            end else begin
                n = (q == '0) ? MAX_COUNT : q - ONE;
            end
`endif
        end
    end

    always_comb begin
        ex = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            ex[i] = jk_excite(n[i], q[i]);
        end
    end

    for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .clr (clr),
            .j   (ex[gi].j),
            .k   (ex[gi].k),
            .q   (q[gi])
        );
    end

    // en & tc with no clr/ld is exactly a wrap (or a saturating attempt).
    always_ff @(posedge clk) begin
        if (clr || ld) begin
            wrapped_q <= 1'b0;
        end else if (tc) begin
            wrapped_q <= 1'b1;
        end
    end

    assign wrapped = wrapped_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
module tb_jk_mod_counter;

    localparam int W = 4;
    localparam int M = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Single counter under test
    logic         clr, en, up, ld;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         tc, wrapped;

    jk_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
        .clk     (clk),
        .clr     (clr),
        .en      (en),
        .up      (up),
        .ld      (ld),
        .d       (d),
        .q       (q),
        .tc      (tc),
        .wrapped (wrapped)
    );

    // Two-digit decade cascade
    logic         c_clr, lo_en;
    logic [W-1:0] lo_q, hi_q;
    logic         lo_tc, hi_tc, lo_wr, hi_wr;

    jk_mod_counter #(.WIDTH(W), .MODULUS(M)) u_lo (
        .clk     (clk),
        .clr     (c_clr),
        .en      (lo_en),
        .up      (1'b1),
        .ld      (1'b0),
        .d       ('0),
        .q       (lo_q),
        .tc      (lo_tc),
        .wrapped (lo_wr)
    );

    jk_mod_counter #(.WIDTH(W), .MODULUS(M)) u_hi (
        .clk     (clk),
        .clr     (c_clr),
        .en      (lo_tc),
        .up      (1'b1),
        .ld      (1'b0),
        .d       ('0),
        .q       (hi_q),
        .tc      (hi_tc),
        .wrapped (hi_wr)
    );

    int checks = 0;
    int fails  = 0;

    // Reference model state
    int mq;
    bit mw;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Behavioural model of one clock edge.
    task automatic model_step(input bit c, input bit l, input bit e, input bit u, input int dv);
        if (c) begin
            mq = 0;
            mw = 0;
        end else if (l) begin
            mq = (dv >= M) ? M - 1 : dv;
            mw = 0;
        end else if (e) begin
            if (u && mq == M - 1) begin
                mw = 1;
`ifdef JK_MOD_COUNTER_SAT_EN
                mq = M - 1;
`else
                mq = 0;
`endif
            end else if (!u && mq == 0) begin
                mw = 1;
`ifdef JK_MOD_COUNTER_SAT_EN
                mq = 0;
`else
                mq = M - 1;
`endif
            end else begin
                mq = u ? mq + 1 : mq - 1;
            end
        end
    endtask

    // Drive one cycle of inputs, check tc before the edge, q/wrapped after it.
    task automatic cycle(input bit c, input bit l, input bit e, input bit u, input int dv);
        bit exp_tc;
        clr = c;
        ld  = l;
        en  = e;
        up  = u;
        d   = W'(dv);
        #1;
        exp_tc = e && (u ? (mq == M - 1) : (mq == 0));
        chk("tc", {31'b0, tc}, {31'b0, exp_tc});
        @(posedge clk);
        model_step(c, l, e, u, dv);
        #1;
        chk("q", {28'b0, q}, mq);
        chk("wrapped", {31'b0, wrapped}, {31'b0, mw});
    endtask

    initial begin
        int cnt;
        clr = 1'b1; en = 1'b0; up = 1'b1; ld = 1'b0; d = '0;
        c_clr = 1'b1; lo_en = 1'b0;
        mq = 0;
        mw = 0;

        // Reset: clr twice with en=1, up=1
        cycle(1, 0, 1, 1, 0);
        cycle(1, 0, 1, 1, 0);

        // Up count through the wrap, then down wrap from 0
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, 1, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);

        // Load priority and clamp
        cycle(0, 1, 1, 1, 13);
        cycle(0, 1, 0, 1, 4);
        cycle(0, 1, 1, 0, 15);
        cycle(0, 0, 1, 0, 0);

        // Saturation scenario (wraps in the default build, model follows build)
        cycle(0, 1, 0, 1, 9);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 0, 0);

        // Clear mid-count wins over load and enable
        cycle(0, 0, 1, 1, 0);
        cycle(1, 1, 1, 1, 7);

        // Random stimulus
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) != 0), 1'($urandom), int'($urandom_range(0, 15)));
        end

        // Cascade: 100 counts brings {hi,lo} back to 00
        c_clr = 1'b1;
        lo_en = 1'b1;
        @(posedge clk);
        #1;
        c_clr = 1'b0;
        chk("casc_rst_lo", {28'b0, lo_q}, 0);
        chk("casc_rst_hi", {28'b0, hi_q}, 0);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            cnt = (cnt + 1) % 100;
            chk("casc_lo", {28'b0, lo_q}, cnt % 10);
            chk("casc_hi", {28'b0, hi_q}, cnt / 10);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
